// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - P7 fetch stage: fetch PC, F/D register, fetch AdEL check, delay-slot and redirects
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h00003000,
  parameter logic [31:0] HANDLER_PC = 32'h00004180,
  parameter logic [31:0] IM_LO      = 32'h00003000,
  parameter logic [31:0] IM_HI      = 32'h00006ffc,
  parameter logic [4:0]  ADEL_CODE  = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        d_is_branch,
  input  logic [31:0] im_instr,
  output logic [31:0] f_pc,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic        d_bd,
  output logic [4:0]  d_exccode
);

  logic        adel;
  logic [4:0]  f_exccode;
  logic [31:0] f_instr;

  // A faulting fetch must never leak IM data downstream; a nop travels with the code.
  always_comb begin
    adel      = (f_pc[1:0] != 2'b00) || (f_pc < IM_LO) || (f_pc > IM_HI);
    f_exccode = adel ? ADEL_CODE : 5'd0;
    f_instr   = adel ? 32'h0 : im_instr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc      <= RESET_PC;
      d_pc      <= 32'h0;
      d_instr   <= 32'h0;
      d_bd      <= 1'b0;
      d_exccode <= 5'd0;
    end else if (req) begin
      f_pc      <= HANDLER_PC;
      d_pc      <= HANDLER_PC;
      d_instr   <= 32'h0;
      d_bd      <= 1'b0;
      d_exccode <= 5'd0;
    end else if (eret) begin
      f_pc      <= epc;
      d_pc      <= epc;
      d_instr   <= 32'h0;
      d_bd      <= 1'b0;
      d_exccode <= 5'd0;
    end else if (!stall) begin
      // d_bd is only sampled on a real advance so a stalled branch cannot tag F early.
      f_pc      <= npc;
      d_pc      <= f_pc;
      d_instr   <= f_instr;
      d_exccode <= f_exccode;
      d_bd      <= d_is_branch;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc, epc, im_instr;
  logic        stall, req, eret, d_is_branch;
  logic [31:0] f_pc, d_pc, d_instr;
  logic        d_bd;
  logic [4:0]  d_exccode;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_bd;
    logic [4:0]  d_exccode;
  } exp_t;

  exp_t sbq[$];
  exp_t m;

  fetch_stage dut (
    .clk(clk), .reset(reset), .npc(npc), .stall(stall), .req(req),
    .eret(eret), .epc(epc), .d_is_branch(d_is_branch), .im_instr(im_instr),
    .f_pc(f_pc), .d_pc(d_pc), .d_instr(d_instr), .d_bd(d_bd), .d_exccode(d_exccode)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h00003000) || (a > 32'h00006ffc);
  endfunction

  task automatic check_all(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sbq_empty"}, 32'h1, 32'h0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_f_pc"}, f_pc, e.f_pc);
      chk({tag, "_d_pc"}, d_pc, e.d_pc);
      chk({tag, "_d_instr"}, d_instr, e.d_instr);
      chk({tag, "_d_bd"}, 32'(d_bd), 32'(e.d_bd));
      chk({tag, "_d_exccode"}, 32'(d_exccode), 32'(e.d_exccode));
    end
  endtask

  // Drive one cycle of inputs at the falling edge, predict, then check after the rising edge.
  task automatic step(input string tag, input logic [31:0] n, input logic st, input logic rq,
                      input logic er, input logic [31:0] ep, input logic br);
    npc = n; stall = st; req = rq; eret = er; epc = ep; d_is_branch = br;
    im_instr = 32'h24010001;
    if (rq) begin
      m.f_pc = 32'h00004180; m.d_pc = 32'h00004180;
      m.d_instr = 32'h0; m.d_bd = 1'b0; m.d_exccode = 5'd0;
    end else if (er) begin
      m.f_pc = ep; m.d_pc = ep;
      m.d_instr = 32'h0; m.d_bd = 1'b0; m.d_exccode = 5'd0;
    end else if (!st) begin
      m.d_pc = m.f_pc;
      m.d_instr = bad_addr(m.f_pc) ? 32'h0 : im_instr;
      m.d_exccode = bad_addr(m.f_pc) ? 5'd4 : 5'd0;
      m.d_bd = br;
      m.f_pc = n;
    end
    sbq.push_back(m);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; npc = 32'h0; stall = 1'b0; req = 1'b0; eret = 1'b0;
    epc = 32'h0; d_is_branch = 1'b0; im_instr = 32'h24010001;
    m = '{f_pc: 32'h00003000, d_pc: 32'h0, d_instr: 32'h0, d_bd: 1'b0, d_exccode: 5'd0};
    repeat (2) @(posedge clk);
    #1;
    sbq.push_back(m);
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    step("seq1", m.f_pc + 32'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("seq2", m.f_pc + 32'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("seq2_f_pc_lit", f_pc, 32'h00003008);
    chk("seq2_d_pc_lit", d_pc, 32'h00003004);

    step("stall1", m.f_pc + 32'd4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step("stall2", m.f_pc + 32'd4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("stall_hold_lit", f_pc, 32'h00003008);
    chk("stall_bd_lit", 32'(d_bd), 32'h0);

    step("br_adv", m.f_pc + 32'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("resume_lit", f_pc, 32'h0000300c);
    chk("bd_set_lit", 32'(d_bd), 32'h1);
    step("br_clr", 32'h00003002, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    step("mis_in_d", 32'h00007000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_exc_lit", 32'(d_exccode), 32'd4);
    chk("mis_pc_lit", d_pc, 32'h00003002);
    step("hi_in_d", 32'h00006ffc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("hi_exc_lit", 32'(d_exccode), 32'd4);
    chk("hi_instr_lit", d_instr, 32'h0);
    step("imhi_fetch", 32'h00002ffc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("imhi_exc_lit", 32'(d_exccode), 32'd0);
    step("below_lo", 32'h00003000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("lo_fetch", 32'h00003004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    step("req_all", 32'h00003008, 1'b1, 1'b1, 1'b1, 32'h00003010, 1'b1);
    chk("req_f_pc_lit", f_pc, 32'h00004180);
    step("post_req", m.f_pc + 32'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    step("eret_stall", m.f_pc + 32'd4, 1'b1, 1'b0, 1'b1, 32'h00003010, 1'b1);
    chk("eret_d_pc_lit", d_pc, 32'h00003010);

    #2;
    reset = 1'b0;
    #1;
    chk("async_f_pc", f_pc, 32'h00003000);
    chk("async_d_pc", d_pc, 32'h0);
    chk("async_d_bd", 32'(d_bd), 32'h0);
    m = '{f_pc: 32'h00003000, d_pc: 32'h0, d_instr: 32'h0, d_bd: 1'b0, d_exccode: 5'd0};
    @(negedge clk);
    reset = 1'b1;
    step("post_rst", 32'h00003004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the P7 pipeline: holds the architectural fetch PC (F_PC).
- Feeds F_PC to the next-PC logic and the instruction memory, and accepts the computed next PC back.
- Contains the F/D pipeline register, fetch address-exception detection, delay-slot tracking, and the stall, exception-entry and eret redirects.
- Sits between next-PC logic / IM and the decode stage.

Parameters:
- RESET_PC, 32'h00003000, F_PC value after reset.
- HANDLER_PC, 32'h00004180, exception/interrupt handler entry.
- IM_LO, 32'h00003000, lowest legal fetch address.
- IM_HI, 32'h00006ffc, highest legal fetch address.
- ADEL_CODE, 5'd4, ExcCode for a fetch address error.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- npc  input  32  next PC from next-PC logic (combinational function of F_PC).
- stall  input  1  hazard stall: hold F and D.
- req  input  1  exception/interrupt taken this cycle: redirect to handler.
- eret  input  1  eret committing: redirect to epc.
- epc  input  32  return address from CP0.
- d_is_branch  input  1  instruction currently in D is a branch/jump.
- im_instr  input  32  IM read data for address F_PC (combinational).
- f_pc  output  32  current fetch PC.
- d_pc  output  32  PC of instruction in D.
- d_instr  output  32  instruction in D.
- d_bd  output  1  instruction in D is a branch-delay slot.
- d_exccode  output  5  fetch exception code carried into D (0 = none).

Behaviour:
- Asynchronous reset (reset=0): f_pc=RESET_PC; d_pc=0, d_instr=0, d_bd=0, d_exccode=0. Reset mid-stall or mid-redirect wins immediately.
- Fetch check (combinational on f_pc): adel = (f_pc[1:0]!=0) | (f_pc<IM_LO) | (f_pc>IM_HI), compared unsigned.
  - f_exccode = adel ? ADEL_CODE : 0.
  - f_instr = adel ? 32'h0 : im_instr. A nop is passed down on AdEL and never raw IM data.
- Each rising edge, priority req > eret > stall > normal:
  - req: f_pc<=HANDLER_PC; d_pc<=HANDLER_PC; d_instr<=0; d_bd<=0; d_exccode<=0. This is a bubble.
  - eret (req=0): f_pc<=epc; D flushed as for req, but d_pc<=epc. No delay slot executes after eret.
  - stall (req=0, eret=0): f_pc, d_pc, d_instr, d_bd, d_exccode all hold.
  - normal: f_pc<=npc; d_pc<=f_pc; d_instr<=f_instr; d_exccode<=f_exccode; d_bd<=d_is_branch.
- Delay slot: d_bd is sampled only on normal advance, so a stalled branch in D does not mark the stalled F instruction early.
- f_pc is not forced aligned. A misaligned npc, e.g. a jr target, is loaded as-is and flagged as AdEL when it reaches D.
- No wrap handling: npc=32'hfffffffc+4 arithmetic is the next-PC block's concern. Here it is simply out of range and raises AdEL.
- Latency: F_PC to D outputs is 1 cycle; redirects take effect on the next edge.
- All outputs come directly from registers; none are combinational.

Test Plan:
- Reset then release, npc=f_pc+4, im_instr=32'h24010001, no stall -> f_pc 3000, 3004, 3008 on successive edges; d_pc lags one cycle; d_instr=24010001; d_exccode=0.
- Assert stall 2 cycles at f_pc=3008 -> f_pc and all d_* frozen for 2 edges; resumes at 300c with no skipped or duplicated PC.
- Set d_is_branch=1 for one normal edge -> next d_bd=1. Set d_is_branch=1 while stall=1 -> d_bd unchanged until the first non-stall edge.
- Drive npc=32'h00003002, then npc=32'h00007000 -> when each reaches D: d_exccode=4, d_instr=0, d_pc=3002 and 7000 respectively.
- req=1 together with stall=1 and eret=1 -> f_pc=4180, d_pc=4180, d_instr=0, d_bd=0, d_exccode=0.
- eret=1 with epc=32'h00003010 during stall=1 -> f_pc=3010, D flushed with d_pc=3010. Then assert reset low mid-cycle -> f_pc=3000 immediately, before the next edge.
